// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: one shared decoder and a refresh
// scanner with hex mode, leading-zero blanking, anti-ghost blank interval and frame strobe.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int HEX_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q, frame_d;

    logic                  slot_end;
    logic                  slot_lit;
    logic                  lz_run;
    logic [3:0]            code;
    logic [NUM_DIGITS-1:0] lz_mask;

    // With no blank interval the anode stays on for the whole slot.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign slot_lit = 1'b1;
        end else begin : g_blank
            assign slot_lit = (cnt_q >= CW'(BLANK_CYCLES));
        end
    endgenerate

    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] s;
        s = 7'b1111111;
        case (c)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        if (c > 4'h9 && HEX_MODE == 0) begin
            s = 7'b1111111;
        end
        return s;
    endfunction

    // A digit is a leading zero when it and every more-significant code are zero.
    always_comb begin
        lz_mask = '0;
        lz_run  = blank_lz;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run     = lz_run & (digits[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_run;
        end
    end

    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        if (enable) begin
            cnt_d = slot_end ? '0 : cnt_q + CW'(1);
            if (slot_end) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end
        end

        code    = digits[{idx_q, 2'b00} +: 4];
        seg_d   = lz_mask[idx_q] ? 7'b1111111 : decode(code);
        dp_d    = ~dp_in[idx_q];
        an_d    = '1;
        if (enable && slot_lit) begin
            an_d = ~(NUM_DIGITS'(1) << idx_q);
        end
        frame_d = enable && slot_end && (idx_q == IDX_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: 4-digit decimal and hex instances plus a
// single-digit instance with no blank interval.
module tb_seven_seg_scan_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;

    logic [6:0] seg, seg_h, seg_1;
    logic        dp, dp_h, dp_1;
    logic [3:0]  an, an_h;
    logic [0:0]  an_1;
    logic        ft, ft_h, ft_1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [6:0] tbl [4];

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(0)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .digits(digits), .dp_in(dp_in),
        .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame_tick(ft));

    seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1)) u_hex (
        .clk(clk), .reset(reset), .enable(enable), .digits(digits), .dp_in(dp_in),
        .blank_lz(blank_lz), .seg(seg_h), .dp(dp_h), .an(an_h), .frame_tick(ft_h));

    seven_seg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(3), .BLANK_CYCLES(0), .HEX_MODE(0)) u_one (
        .clk(clk), .reset(reset), .enable(enable), .digits(digits[3:0]), .dp_in(dp_in[0:0]),
        .blank_lz(blank_lz), .seg(seg_1), .dp(dp_1), .an(an_1), .frame_tick(ft_1));

    // Pulse reset across one rising edge; returns on the falling edge where it is released.
    task automatic restart();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_an [6];
        exp_an = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD};
        reset = 1'b1; enable = 1'b1; digits = 16'h9876; dp_in = 4'b0100; blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({seg, dp, an, ft} !== {7'b1111111, 1'b1, 4'hF, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_hold: seg=%b dp=%b an=%b ft=%b, expected 1111111 1 1111 0", seg, dp, an, ft);
        end
        reset = 1'b0;
        repeat (6) @(negedge clk);
        tests_run++;
        if (an !== 4'b1101 || seg !== 7'b1111000) begin
            tests_failed++;
            $display("FAIL pre_reset_lit: an=%b seg=%b, expected 1101 1111000", an, seg);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (seg !== 7'b1111111) begin
            tests_failed++;
            $display("FAIL async_reset_seg: got %b, expected 1111111", seg);
        end
        tests_run++;
        if (dp !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset_dp: got %b, expected 1", dp);
        end
        tests_run++;
        if (an !== 4'hF) begin
            tests_failed++;
            $display("FAIL async_reset_an: got %b, expected 1111", an);
        end
        tests_run++;
        if (ft !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset_ft: got %b, expected 0", ft);
        end
        @(negedge clk);
        reset = 1'b0;
        // Edge 1 sees cnt=0 (dark), edges 2..4 light digit 0, edge 5 dark, edge 6 digit 1.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tests_run++;
            if (an !== exp_an[k]) begin
                tests_failed++;
                $display("FAIL release_an cycle %0d: got %b, expected %b", k + 1, an, exp_an[k]);
            end
        end
    endtask

    task automatic test_scan();
        int cnt, idx, ticks;
        logic [3:0] e_an;
        logic e_dp, e_ft;
        tbl = '{7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        digits = 16'h9876; dp_in = 4'b0100; blank_lz = 1'b0; enable = 1'b1;
        ticks = 0;
        restart();
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            cnt  = (k - 1) % 4;
            idx  = ((k - 1) / 4) % 4;
            e_an = (cnt == 0) ? 4'hF : ~(4'b0001 << idx);
            e_dp = ~dp_in[idx];
            e_ft = (k % 16 == 0);
            if (ft === 1'b1) ticks++;
            tests_run++;
            if ({an, seg, dp, ft} !== {e_an, tbl[idx], e_dp, e_ft}) begin
                tests_failed++;
                $display("FAIL scan cycle %0d: an=%b seg=%b dp=%b ft=%b, expected an=%b seg=%b dp=%b ft=%b",
                         k, an, seg, dp, ft, e_an, tbl[idx], e_dp, e_ft);
            end
        end
        tests_run++;
        if (ticks != 2) begin
            tests_failed++;
            $display("FAIL scan_frame_count: got %0d, expected 2", ticks);
        end
    endtask

    task automatic test_hex();
        int idx;
        tbl = '{7'b0001000, 7'b0100001, 7'b0000110, 7'b0001110};
        digits = 16'hFEDA; dp_in = 4'b0000; blank_lz = 1'b0; enable = 1'b1;
        restart();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            idx = ((k - 1) / 4) % 4;
            tests_run++;
            if (seg !== 7'b1111111) begin
                tests_failed++;
                $display("FAIL hex_off digit %0d: got %b, expected 1111111", idx, seg);
            end
            tests_run++;
            if (seg_h !== tbl[idx]) begin
                tests_failed++;
                $display("FAIL hex_on digit %0d: got %b, expected %b", idx, seg_h, tbl[idx]);
            end
        end
    endtask

    task automatic test_lz();
        int idx;
        logic [15:0] pat [2];
        logic [6:0]  exp_tbl [2][4];
        pat = '{16'h0000, 16'h0102};
        exp_tbl[0] = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
        exp_tbl[1] = '{7'b0100100, 7'b1000000, 7'b1111001, 7'b1111111};
        blank_lz = 1'b1; dp_in = 4'b0000; enable = 1'b1;
        for (int p = 0; p < 2; p++) begin
            digits = pat[p];
            restart();
            for (int k = 1; k <= 16; k++) begin
                @(negedge clk);
                idx = ((k - 1) / 4) % 4;
                tests_run++;
                if (seg !== exp_tbl[p][idx]) begin
                    tests_failed++;
                    $display("FAIL lz %h digit %0d: got %b, expected %b", pat[p], idx, seg, exp_tbl[p][idx]);
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_enable();
        logic [3:0] exp_an [4];
        exp_an = '{4'b1101, 4'b1101, 4'hF, 4'b1011};
        digits = 16'h9876; dp_in = 4'b0000; blank_lz = 1'b0; enable = 1'b1;
        restart();
        // After 6 edges the scan sits at idx=1, cnt=2.
        repeat (6) @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            tests_run++;
            if (an !== 4'hF || ft !== 1'b0) begin
                tests_failed++;
                $display("FAIL enable_off cycle %0d: an=%b ft=%b, expected 1111 0", k, an, ft);
            end
        end
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (an !== exp_an[k]) begin
                tests_failed++;
                $display("FAIL enable_resume cycle %0d: got %b, expected %b", k, an, exp_an[k]);
            end
        end
    endtask

    task automatic test_single_digit();
        logic e_ft;
        digits = 16'h9876; dp_in = 4'b0000; blank_lz = 1'b1; enable = 1'b1;
        restart();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            e_ft = (k % 3 == 0);
            tests_run++;
            if ({an_1, seg_1, dp_1, ft_1} !== {1'b0, 7'b0000010, 1'b1, e_ft}) begin
                tests_failed++;
                $display("FAIL single cycle %0d: an=%b seg=%b dp=%b ft=%b, expected 0 0000010 1 %b",
                         k, an_1, seg_1, dp_1, ft_1, e_ft);
            end
        end
        blank_lz = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_hex();
        test_lz();
        test_enable();
        test_single_digit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
